kypd_scan: RTL and testbench
============================

# kypd_scan

Matrix-keypad scanner for the 4x4 hex Pmod keypad. It is the input-side counterpart of the multiplexed seven-segment driver. It walks an active-low one-hot column strobe and samples the active-low row lines. It debounces whole-scan results and emits a one-cycle strobe plus a 4-bit hex code per accepted keypress. It sits between the keypad Pmod pins and the front-panel control logic that edits the displayed digits and waveform settings.

## Interface
- `DEBOUNCE_SCANS`, default 4: number of consecutive identical full-scan results required before a result is accepted. Legal range is 1–15.
- `scanclk` in 1: scan clock, the single clock of the block. All logic runs on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `row` in 4: keypad rows, active-low, externally pulled up, asynchronous to `scanclk`.
- `col` out 4: keypad column drive, active-low one-hot. The value 4'b1111 means no column is driven.
- `key_code` out 4: hex value of the last accepted key.
- `key_valid` out 1: one-cycle pulse when a new key is accepted.
- `key_held` out 1: high while the accepted key is still stably pressed.

## Operation
- `row` passes through a 2-flop synchronizer before any use.
- **Scan sequencing**
  - `col_sel[1:0]` and `phase[1:0]` form a 4-bit free-running counter. A full scan takes 16 cycles.
  - `col` = ~(1 << `col_sel`), registered.
  - Column order is 0,1,2,3, giving patterns 1110, 1101, 1011, 0111.
  - Rows are sampled only when `phase` = 3. This leaves 1 settle cycle plus 2 synchronizer cycles.
- **Per-scan accumulation**
  - Each sampled low row bit counts as a pressed key.
  - The block records the first pressed key in scan order: lowest column, then lowest row.
  - It counts pressed keys, saturating at 2.
- **End of scan** (`col_sel` = 3, `phase` = 3): the accumulator is converted to a candidate.
  - NONE: 0 keys pressed.
  - KEY(code): exactly 1 key pressed.
  - MULTI: 2 or more keys pressed.
  - The accumulator is then cleared for the next scan.
- **Key map** (row r, column c):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- **Debounce**
  - If the candidate equals the previous candidate, `stable_cnt` increments, saturating at `DEBOUNCE_SCANS`.
  - Otherwise `stable_cnt` is set to 1 and the previous candidate is updated.
- **Acceptance** happens only on the scan where `stable_cnt` first reaches `DEBOUNCE_SCANS`. The accepted candidate then updates the outputs:
  - KEY(c), when `key_held` = 0 or c differs from `key_code`: `key_code` <= c, `key_valid` pulses, `key_held` <= 1.
  - KEY(c), when c equals the held `key_code`: no action.
  - NONE: `key_held` <= 0. `key_code` is retained.
  - MULTI: ghost/chord. No pulse, `key_code` is unchanged, `key_held` <= 0.
- Sliding from one key to another without a stable NONE in between produces a pulse for the new key.

## Timing
- **Reset values**
  - `col` = 4'b1111.
  - `key_code` = 0, `key_valid` = 0, `key_held` = 0.
  - Scan counter = 0, accumulator cleared, `stable_cnt` = 0, previous candidate = NONE.
- The first column is driven (`col` = 1110) on the first `scanclk` edge after `rst` falls.
- Sample for column c, row r: the synchronized `row` at `phase` 3 reflects the pins as of 2 cycles earlier.
- `key_valid` goes high the cycle after the end-of-scan sample that completes debounce. It lasts exactly 1 cycle. `key_code` is valid in the same cycle and stays stable until the next accept.
- **Press latency:** at most 16·`DEBOUNCE_SCANS` + 19 cycles from the press becoming stable at the pins. With the default this is 83 cycles.
- `key_held` falls in the same cycle position, after `DEBOUNCE_SCANS` consecutive NONE scans.
- **Reset mid-scan:** the partial scan is discarded and no pulse is generated. Scanning restarts at column 0.

## Structure
- Package `kypd_pkg` holds:
  - the candidate-kind constants NONE, KEY, MULTI;
  - the row/column to hex key-map function;
  - the scan-length constants (4 phases, 4 columns).
- Sub-module `kypd_debounce` compares candidates, runs the saturating `stable_cnt`, and makes the accept decision. Its inputs are a candidate and an end-of-scan strobe. Its outputs are `key_code`, `key_valid` and `key_held`.
- The top level holds the synchronizer, the scan counter, column drive and the accumulator.

## Test plan
- **Idle after reset:** release `rst` with no keys pressed.
  - `col` cycles 1110, 1101, 1011, 0111, each for 4 cycles, repeating.
  - `key_valid` never asserts and `key_held` = 0.
- **Single press:** hold '5' (r1, c1) for 10 scans, then release for 6 scans.
  - Exactly one `key_valid` with `key_code` = 5, after 4 stable scans.
  - `key_held` is 1, then falls after 4 NONE scans.
  - `key_code` stays 5.
- **Bouncing press:** '9' toggles pressed/released on alternate scans for 5 scans, then is held stable.
  - A single pulse with `key_code` = 9.
  - No pulse during the bounce.
- **Chord:** press '1' and '2' together for 8 scans after a prior accepted 'A'.
  - No pulse, `key_code` stays A (hex) and `key_held` = 0.
- **Slide:** '3' is accepted and held, then switches directly to 'D' (r3, c3).
  - A second pulse with `key_code` = D.
- **Reset mid-operation:** assert `rst` during scan 3 of holding '0'.
  - Outputs return to reset values at once.
  - After release, a pulse with code 0 appears only after 4 full new scans.

Source files
------------

// File: rtl/kypd_pkg.sv
// Shared definitions for the 4x4 hex keypad scanner: candidate kinds,
// scan geometry and the row/column to hex key map.
package kypd_pkg;

  localparam int NUM_PHASES = 4;
  localparam int NUM_COLS   = 4;
  localparam int NUM_ROWS   = 4;

  typedef enum logic [1:0] {
    CAND_NONE  = 2'd0,
    CAND_KEY   = 2'd1,
    CAND_MULTI = 2'd2
  } cand_kind_t;

  // code is forced to zero for NONE/MULTI so whole-struct compares are exact
  typedef struct packed {
    cand_kind_t kind;
    logic [3:0] code;
  } cand_t;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;
      4'h1: k = 4'h2;
      4'h2: k = 4'h3;
      4'h3: k = 4'hA;
      4'h4: k = 4'h4;
      4'h5: k = 4'h5;
      4'h6: k = 4'h6;
      4'h7: k = 4'hB;
      4'h8: k = 4'h7;
      4'h9: k = 4'h8;
      4'hA: k = 4'h9;
      4'hB: k = 4'hC;
      4'hC: k = 4'h0;
      4'hD: k = 4'hF;
      4'hE: k = 4'hE;
      default: k = 4'hD;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/kypd_debounce.sv
// Whole-scan debouncer: counts consecutive identical candidates and turns the
// scan that first reaches the threshold into key_code / key_valid / key_held.
module kypd_debounce
  import kypd_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       scanclk,
  input  logic       rst,
  input  logic       eos,
  input  cand_t      cand,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam logic [3:0] TARGET = 4'(DEBOUNCE_SCANS);

  cand_t      prev_cand;
  logic [3:0] stable_cnt;
  logic [3:0] cnt_nxt;
  logic       same;
  logic       accept;

  always_comb begin
    same = (cand == prev_cand);
    if (!same)
      cnt_nxt = 4'd1;
    else if (stable_cnt >= TARGET)
      cnt_nxt = TARGET;
    else
      cnt_nxt = stable_cnt + 4'd1;
    // a differing candidate restarts at 1, which is itself a first reach when TARGET is 1
    accept = eos && (cnt_nxt == TARGET) && (!same || (stable_cnt != TARGET));
  end

  always_ff @(posedge scanclk or posedge rst) begin
    if (rst) begin
      prev_cand  <= '{kind: CAND_NONE, code: 4'h0};
      stable_cnt <= 4'd0;
      key_code   <= 4'h0;
      key_valid  <= 1'b0;
      key_held   <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (eos) begin
        prev_cand  <= cand;
        stable_cnt <= cnt_nxt;
      end
      if (accept) begin
        case (cand.kind)
          CAND_KEY: begin
            if (!key_held || (cand.code != key_code)) begin
              key_code  <= cand.code;
              key_valid <= 1'b1;
              key_held  <= 1'b1;
            end
          end
          default: key_held <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: rtl/kypd_scan.sv
// 4x4 keypad scanner: drives an active-low column strobe, samples synchronized
// rows, accumulates one scan into a candidate and hands it to the debouncer.
module kypd_scan
  import kypd_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       scanclk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  logic [3:0] row_meta;
  logic [3:0] row_sync;
  logic [1:0] col_sel;
  logic [1:0] phase;
  logic [1:0] acc_cnt;
  logic [3:0] acc_code;

  logic       sample;
  logic       eos;
  logic [2:0] col_hits;
  logic [1:0] first_row;
  logic [2:0] sum;
  logic [1:0] merged_cnt;
  logic [3:0] merged_code;
  cand_t      cand;

  // Stage: row synchronizer, scan counter and registered column drive
  always_ff @(posedge scanclk or posedge rst) begin
    if (rst) begin
      row_meta         <= 4'hF;
      row_sync         <= 4'hF;
      {col_sel, phase} <= 4'd0;
      col              <= 4'b1111;
    end else begin
      row_meta         <= row;
      row_sync         <= row_meta;
      {col_sel, phase} <= {col_sel, phase} + 4'd1;
      col              <= ~(4'b0001 << col_sel);
    end
  end

  always_comb begin
    sample    = (phase == 2'(NUM_PHASES - 1));
    eos       = sample && (col_sel == 2'(NUM_COLS - 1));
    col_hits  = 3'd0;
    first_row = 2'd0;
    // walk downward so the lowest pressed row is the one left in first_row
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      if (!row_sync[r]) begin
        col_hits  = col_hits + 3'd1;
        first_row = 2'(r);
      end
    end

    sum         = {1'b0, acc_cnt} + col_hits;
    merged_cnt  = acc_cnt;
    merged_code = acc_code;
    if (sample) begin
      merged_cnt = (sum >= 3'd2) ? 2'd2 : sum[1:0];
      if ((acc_cnt == 2'd0) && (col_hits != 3'd0))
        merged_code = key_map(first_row, col_sel);
    end

    cand.kind = CAND_NONE;
    cand.code = 4'h0;
    if (merged_cnt == 2'd1) begin
      cand.kind = CAND_KEY;
      cand.code = merged_code;
    end else if (merged_cnt == 2'd2) begin
      cand.kind = CAND_MULTI;
    end
  end

  // Stage: per-scan accumulator, cleared as its result leaves at end of scan
  always_ff @(posedge scanclk or posedge rst) begin
    if (rst) begin
      acc_cnt  <= 2'd0;
      acc_code <= 4'h0;
    end else if (eos) begin
      acc_cnt  <= 2'd0;
      acc_code <= 4'h0;
    end else if (sample) begin
      acc_cnt  <= merged_cnt;
      acc_code <= merged_code;
    end
  end

  kypd_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .scanclk  (scanclk),
    .rst      (rst),
    .eos      (eos),
    .cand     (cand),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

endmodule

// File: tb/tb_kypd_scan.sv
// Directed bench for kypd_scan with a behavioural 4x4 keypad wired to col/row.
module tb_kypd_scan;

  logic        scanclk = 1'b0;
  logic        rst     = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys = 16'h0;

  int   checks = 0;
  int   errors = 0;
  int   pulse_cnt = 0;
  logic [3:0] pulse_code = 4'h0;
  logic vld_d = 1'b0;
  bit   double_pulse = 1'b0;

  always #5 scanclk = ~scanclk;

  kypd_scan #(.DEBOUNCE_SCANS(4)) dut (
    .scanclk  (scanclk),
    .rst      (rst),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  // a pressed key at (r,c) pulls row r low while column c is driven low
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col[c] && keys[r*4+c]) row[r] = 1'b0;
  end

  always @(negedge scanclk) begin
    if (key_valid) begin
      pulse_cnt  = pulse_cnt + 1;
      pulse_code = key_code;
      if (vld_d) double_pulse = 1'b1;
    end
    vld_d = key_valid;
  end

  function automatic logic [15:0] kbit(input int r, input int c);
    return 16'h1 << (r*4 + c);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge scanclk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    checks++; if (col !== 4'b1111) begin errors++; $display("FAIL reset_col got %b exp 1111", col); end
    checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL reset_code got %h exp 0", key_code); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", key_valid); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held got %b exp 0", key_held); end
  endtask

  task automatic test_idle();
    logic [3:0] exp_col;
    rst = 1'b0;
    for (int n = 1; n <= 96; n++) begin
      tick(1);
      exp_col = ~(4'b0001 << (((n - 1) >> 2) & 3));
      checks++;
      if (col !== exp_col) begin errors++; $display("FAIL idle_col cycle %0d got %b exp %b", n, col, exp_col); end
      checks++;
      if (key_valid !== 1'b0 || key_held !== 1'b0) begin
        errors++; $display("FAIL idle_quiet cycle %0d got valid %b held %b exp 0 0", n, key_valid, key_held);
      end
    end
  endtask

  task automatic test_single_press();
    int p0;
    p0 = pulse_cnt;
    keys = kbit(1, 1);
    tick(48);
    checks++; if (pulse_cnt - p0 != 0) begin errors++; $display("FAIL single_early got %0d pulses exp 0", pulse_cnt - p0); end
    tick(35);
    checks++; if (pulse_cnt - p0 != 1) begin errors++; $display("FAIL single_latency got %0d pulses exp 1", pulse_cnt - p0); end
    checks++; if (pulse_code !== 4'h5) begin errors++; $display("FAIL single_code got %h exp 5", pulse_code); end
    tick(160 - 83);
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL single_held got %b exp 1", key_held); end
    checks++; if (pulse_cnt - p0 != 1) begin errors++; $display("FAIL single_count got %0d exp 1", pulse_cnt - p0); end
    keys = 16'h0;
    tick(96);
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL single_release_held got %b exp 0", key_held); end
    checks++; if (key_code !== 4'h5) begin errors++; $display("FAIL single_release_code got %h exp 5", key_code); end
    checks++; if (pulse_cnt - p0 != 1) begin errors++; $display("FAIL single_release_count got %0d exp 1", pulse_cnt - p0); end
  endtask

  task automatic test_bounce();
    int p0;
    p0 = pulse_cnt;
    for (int i = 0; i < 5; i++) begin
      keys = (i % 2 == 0) ? kbit(2, 2) : 16'h0;
      tick(16);
    end
    checks++; if (pulse_cnt - p0 != 0) begin errors++; $display("FAIL bounce_quiet got %0d pulses exp 0", pulse_cnt - p0); end
    keys = kbit(2, 2);
    tick(96);
    checks++; if (pulse_cnt - p0 != 1) begin errors++; $display("FAIL bounce_count got %0d exp 1", pulse_cnt - p0); end
    checks++; if (pulse_code !== 4'h9) begin errors++; $display("FAIL bounce_code got %h exp 9", pulse_code); end
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL bounce_held got %b exp 1", key_held); end
    keys = 16'h0;
    tick(96);
  endtask

  task automatic test_chord();
    int p0;
    p0 = pulse_cnt;
    keys = kbit(0, 3);
    tick(96);
    checks++; if (pulse_cnt - p0 != 1) begin errors++; $display("FAIL chord_prior_count got %0d exp 1", pulse_cnt - p0); end
    checks++; if (pulse_code !== 4'hA) begin errors++; $display("FAIL chord_prior_code got %h exp A", pulse_code); end
    keys = kbit(0, 0) | kbit(0, 1);
    tick(128);
    checks++; if (pulse_cnt - p0 != 1) begin errors++; $display("FAIL chord_pulse got %0d exp 1", pulse_cnt - p0); end
    checks++; if (key_code !== 4'hA) begin errors++; $display("FAIL chord_code got %h exp A", key_code); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL chord_held got %b exp 0", key_held); end
    keys = 16'h0;
    tick(96);
  endtask

  task automatic test_slide();
    int p0;
    p0 = pulse_cnt;
    keys = kbit(0, 2);
    tick(96);
    checks++; if (pulse_cnt - p0 != 1) begin errors++; $display("FAIL slide_first_count got %0d exp 1", pulse_cnt - p0); end
    checks++; if (pulse_code !== 4'h3) begin errors++; $display("FAIL slide_first_code got %h exp 3", pulse_code); end
    keys = kbit(3, 3);
    tick(96);
    checks++; if (pulse_cnt - p0 != 2) begin errors++; $display("FAIL slide_second_count got %0d exp 2", pulse_cnt - p0); end
    checks++; if (pulse_code !== 4'hD) begin errors++; $display("FAIL slide_second_code got %h exp D", pulse_code); end
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL slide_held got %b exp 1", key_held); end
  endtask

  task automatic test_reset_mid();
    int p0;
    int n;
    keys = kbit(3, 0);
    p0 = pulse_cnt;
    tick(40);
    checks++; if (pulse_cnt - p0 != 0) begin errors++; $display("FAIL rstmid_early got %0d pulses exp 0", pulse_cnt - p0); end
    rst = 1'b1;
    #1;
    checks++; if (col !== 4'b1111) begin errors++; $display("FAIL rstmid_col got %b exp 1111", col); end
    checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL rstmid_code got %h exp 0", key_code); end
    checks++; if (key_held !== 1'b0 || key_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_flags got held %b valid %b exp 0 0", key_held, key_valid);
    end
    tick(3);
    rst = 1'b0;
    p0 = pulse_cnt;
    n = 0;
    while (key_valid !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    checks++; if (n != 64) begin errors++; $display("FAIL rstmid_latency got %0d cycles exp 64", n); end
    checks++; if (key_code !== 4'h0 || key_held !== 1'b1) begin
      errors++; $display("FAIL rstmid_accept got code %h held %b exp 0 1", key_code, key_held);
    end
    checks++; if (pulse_cnt - p0 != 1) begin errors++; $display("FAIL rstmid_count got %0d exp 1", pulse_cnt - p0); end
    keys = 16'h0;
    tick(32);
    checks++; if (double_pulse !== 1'b0) begin errors++; $display("FAIL pulse_width got multi-cycle %b exp 0", double_pulse); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_press();
    test_bounce();
    test_chord();
    test_slide();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
